// File: rtl/md_sched_pkg.sv
// Shared types and default latencies for the multiply/divide scheduler.
// Imported by the interface, the timer and the scheduler top.
package md_sched_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_t;

  localparam int MUL_DELAY_DEF = 3;
  localparam int DIV_DELAY_DEF = 32;

  function automatic logic op_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// Bundle between the EX lanes, the shared mul/div datapath and the scheduler.
// slave is the scheduler's view, master the pipeline/datapath side.
interface md_sched_if;
  import md_sched_pkg::*;

  // Handshake: req[i] is lane i's valid; md_stall is the inverse of ready.
  // A lane's op is consumed once it has written HI/LO; req and the lane's
  // op/operands must hold stable while md_stall or stall_ext is high.
  logic [1:0]        req;
  md_op_t [1:0]      op;
  logic [1:0][31:0]  srca;
  logic [1:0][31:0]  srcb;
  logic              flush;
  logic              stall_ext;
  logic              md_stall;
  logic              busy;

  logic              mul_start;
  logic              div_start;
  logic              dp_signed;
  logic [31:0]       dp_a;
  logic [31:0]       dp_b;
  logic [31:0]       mul_hi;
  logic [31:0]       mul_lo;
  logic [31:0]       div_q;
  logic [31:0]       div_r;

  logic              hilo_we;
  logic [31:0]       hi_wd;
  logic [31:0]       lo_wd;

  md_state_t         dbg_state;
  logic [1:0]        dbg_served;
  logic [7:0]        dbg_cnt;

  modport slave (
    input  req, op, srca, srcb, flush, stall_ext,
    input  mul_hi, mul_lo, div_q, div_r,
    output md_stall, busy, mul_start, div_start, dp_signed, dp_a, dp_b,
    output hilo_we, hi_wd, lo_wd,
    output dbg_state, dbg_served, dbg_cnt
  );

  modport master (
    output req, op, srca, srcb, flush, stall_ext,
    output mul_hi, mul_lo, div_q, div_r,
    input  md_stall, busy, mul_start, div_start, dp_signed, dp_a, dp_b,
    input  hilo_we, hi_wd, lo_wd,
    input  dbg_state, dbg_served, dbg_cnt
  );

endinterface

// File: rtl/md_sched_timer.sv
// Loadable down-counter that measures the fixed mul/div latency.
// Stops at zero; reset and flush both clear it.
module md_sched_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/md_sched.sv
// Serialises MULT/MULTU/DIV/DIVU from both EX lanes onto one shared mul/div
// datapath, older lane (1) first, and stalls EX until every lane has written.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MUL_DELAY = MUL_DELAY_DEF,
  parameter int DIV_DELAY = DIV_DELAY_DEF
) (
  input logic       clk,
  input logic       reset,
  md_sched_if.slave bus
);

  localparam int MAX_DELAY = (MUL_DELAY > DIV_DELAY) ? MUL_DELAY : DIV_DELAY;
  localparam int CNT_W     = $clog2(MAX_DELAY);

  // The start cycle itself counts as the DELAY-1 step, so the register is
  // loaded with DELAY-2 and reaches zero in cycle t+DELAY-1 (needs DELAY >= 2).
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_DELAY - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_DELAY - 2);

  md_state_t        state;
  logic [1:0]       served;
  logic             lane;
  md_op_t           cur_op;

  logic [1:0]       pending;
  logic             sel_lane;
  md_op_t           sel_op;
  logic             start;
  logic             done;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  logic             act_lane;
  md_op_t           act_op;
  logic             drive_dp;

  assign pending  = bus.req & ~served;
  assign sel_lane = pending[1];
  assign sel_op   = bus.op[sel_lane];
  assign start    = (state == IDLE) && (pending != 2'b00) && !bus.flush && !reset;
  assign done     = (state == RUN) && cnt_zero && !bus.flush && !reset;

  md_sched_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (bus.flush),
    .load     (start),
    .load_val (op_is_div(sel_op) ? DIV_LOAD : MUL_LOAD),
    .dec      (state == RUN),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      served <= 2'b00;
      lane   <= 1'b0;
      cur_op <= MD_MULT;
    end else if (bus.flush) begin
      state  <= IDLE;
      served <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (pending != 2'b00) begin
            lane   <= sel_lane;
            cur_op <= sel_op;
            state  <= RUN;
          end else if (!bus.stall_ext) begin
            // Instructions leave EX this cycle; forget what was completed.
            served <= 2'b00;
          end
        end
        RUN: begin
          if (cnt_zero) begin
            served[lane] <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // While running, keep presenting the in-service lane's operands.
  assign act_lane = (state == RUN) ? lane : sel_lane;
  assign act_op   = (state == RUN) ? cur_op : sel_op;
  assign drive_dp = !reset && ((state == RUN) || (pending != 2'b00));

  assign bus.dp_a      = drive_dp ? bus.srca[act_lane] : 32'd0;
  assign bus.dp_b      = drive_dp ? bus.srcb[act_lane] : 32'd0;
  assign bus.dp_signed = drive_dp && op_is_signed(act_op);
  assign bus.mul_start = start && !op_is_div(sel_op);
  assign bus.div_start = start && op_is_div(sel_op);

  assign bus.hilo_we = done;
  assign bus.hi_wd   = !done ? 32'd0 : (op_is_div(cur_op) ? bus.div_r : bus.mul_hi);
  assign bus.lo_wd   = !done ? 32'd0 : (op_is_div(cur_op) ? bus.div_q : bus.mul_lo);

  assign bus.md_stall = !reset && (pending != 2'b00);
  assign bus.busy     = !reset && (state == RUN);

  assign bus.dbg_state  = state;
  assign bus.dbg_served = served;
  assign bus.dbg_cnt    = 8'(cnt);

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: lane ordering, latency, flush, stall_ext, reset.
// Expected values are hand-derived; HI/LO writes are matched against exp_q.
module tb_md_sched;
  import md_sched_pkg::*;

  localparam int MUL_D = 3;
  localparam int DIV_D = 32;

  logic clk;
  logic reset;
  md_sched_if bus ();

  md_sched #(.MUL_DELAY(MUL_D), .DIV_DELAY(DIV_D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- check / drivers ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req       = 2'b00;
    bus.op[0]     = MD_MULT;
    bus.op[1]     = MD_MULT;
    bus.srca      = '0;
    bus.srcb      = '0;
    bus.flush     = 1'b0;
    bus.stall_ext = 1'b0;
    bus.mul_hi    = 32'd0;
    bus.mul_lo    = 32'd0;
    bus.div_q     = 32'd0;
    bus.div_r     = 32'd0;
  endtask

  task automatic set_lane(input int l, input md_op_t o, input logic [31:0] a, input logic [31:0] b);
    bus.op[l]   = o;
    bus.srca[l] = a;
    bus.srcb[l] = b;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.hilo_we) begin
        check_eq("hilo_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0)
          check_eq("hilo_data", {bus.hi_wd, bus.lo_wd}, exp_q.pop_front());
      end
      if (bus.dbg_state == RUN && !bus.flush)
        check_eq("req_held_in_run", 64'(bus.req != 2'b00), 64'd1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n_start;
    int n_we;
    idle_inputs();
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_state", 64'(bus.dbg_state), 64'(IDLE));
    check_eq("rst_served", 64'(bus.dbg_served), 64'd0);
    check_eq("rst_outs", 64'({bus.md_stall, bus.busy, bus.mul_start, bus.div_start,
                              bus.dp_signed, bus.hilo_we}), 64'd0);
    check_eq("rst_data", {bus.dp_a, bus.dp_b}, 64'd0);
    cyc();

    // Test 1: lane 1 MULT -3*5
    bus.req = 2'b10;
    set_lane(1, MD_MULT, 32'hFFFF_FFFD, 32'd5);
    set_lane(0, MD_DIVU, 32'h0000_1111, 32'h0000_2222);
    bus.mul_hi = 32'hFFFF_FFFF;
    bus.mul_lo = 32'hFFFF_FFF1;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF1);
    for (int c = 0; c <= 4; c++) begin
      if (c == 4) bus.req = 2'b00;
      @(negedge clk);
      check_eq("t1_mul_start", 64'(bus.mul_start), 64'(c == 0));
      check_eq("t1_hilo_we", 64'(bus.hilo_we), 64'(c == 2));
      check_eq("t1_md_stall", 64'(bus.md_stall), 64'(c <= 2));
      if (c == 0) begin
        check_eq("t1_dp_a", 64'(bus.dp_a), 64'h0000_0000_FFFF_FFFD);
        check_eq("t1_dp_b", 64'(bus.dp_b), 64'd5);
        check_eq("t1_signed", 64'(bus.dp_signed), 64'd1);
        check_eq("t1_div_start", 64'(bus.div_start), 64'd0);
      end
      if (c == 2) check_eq("t1_hi_lo", {bus.hi_wd, bus.lo_wd}, 64'hFFFF_FFFF_FFFF_FFF1);
      if (c == 3) check_eq("t1_served", 64'(bus.dbg_served), 64'b10);
      if (c == 4) check_eq("t1_retired", 64'(bus.dbg_served), 64'd0);
      cyc();
    end

    // Test 2: both lanes MULTU, lane 1 first
    idle_inputs();
    bus.req = 2'b11;
    set_lane(1, MD_MULTU, 32'd7, 32'd6);
    set_lane(0, MD_MULTU, 32'd9, 32'd10);
    bus.mul_lo = 32'h2A;
    exp_q.push_back(64'h2A);
    exp_q.push_back(64'h2A);
    for (int c = 0; c <= 7; c++) begin
      if (c == 7) bus.req = 2'b00;
      @(negedge clk);
      check_eq("t2_mul_start", 64'(bus.mul_start), 64'(c == 0 || c == 3));
      check_eq("t2_hilo_we", 64'(bus.hilo_we), 64'(c == 2 || c == 5));
      check_eq("t2_md_stall", 64'(bus.md_stall), 64'(c <= 5));
      check_eq("t2_busy", 64'(bus.busy), 64'(c == 1 || c == 2 || c == 4 || c == 5));
      if (c == 0) check_eq("t2_dp_a_l1", 64'(bus.dp_a), 64'd7);
      if (c == 3) check_eq("t2_dp_a_l0", 64'(bus.dp_a), 64'd9);
      if (c == 3) check_eq("t2_signed", 64'(bus.dp_signed), 64'd0);
      if (c == 6) check_eq("t2_served", 64'(bus.dbg_served), 64'b11);
      cyc();
    end

    // Test 3: lane 0 DIVU 100/7
    idle_inputs();
    bus.req = 2'b01;
    set_lane(0, MD_DIVU, 32'd100, 32'd7);
    bus.div_q = 32'd14;
    bus.div_r = 32'd2;
    exp_q.push_back({32'd2, 32'd14});
    for (int c = 0; c <= 33; c++) begin
      if (c == 33) bus.req = 2'b00;
      @(negedge clk);
      check_eq("t3_div_start", 64'(bus.div_start), 64'(c == 0));
      check_eq("t3_hilo_we", 64'(bus.hilo_we), 64'(c == 31));
      check_eq("t3_busy", 64'(bus.busy), 64'(c >= 1 && c <= 31));
      check_eq("t3_md_stall", 64'(bus.md_stall), 64'(c <= 31));
      if (c == 0) check_eq("t3_signed", 64'(bus.dp_signed), 64'd0);
      if (c == 31) check_eq("t3_hi_lo", {bus.hi_wd, bus.lo_wd}, {32'd2, 32'd14});
      cyc();
    end

    // Test 4: DIV flushed at t+10, then a fresh MULT at t+12
    idle_inputs();
    bus.req = 2'b10;
    set_lane(1, MD_DIV, 32'hFFFF_FFEC, 32'd3);
    bus.div_q = 32'hFFFF_FFFA;
    bus.div_r = 32'hFFFF_FFFE;
    for (int c = 0; c <= 16; c++) begin
      if (c == 10) bus.flush = 1'b1;
      if (c == 11) begin
        bus.flush = 1'b0;
        bus.req   = 2'b00;
      end
      if (c == 12) begin
        bus.req = 2'b10;
        set_lane(1, MD_MULT, 32'd2, 32'd3);
        bus.mul_lo = 32'd6;
        exp_q.push_back(64'd6);
      end
      if (c == 16) bus.req = 2'b00;
      @(negedge clk);
      check_eq("t4_hilo_we", 64'(bus.hilo_we), 64'(c == 14));
      if (c == 0) check_eq("t4_div_start", 64'(bus.div_start), 64'd1);
      if (c == 0) check_eq("t4_signed", 64'(bus.dp_signed), 64'd1);
      if (c == 10) check_eq("t4_flush_starts", 64'({bus.mul_start, bus.div_start}), 64'd0);
      if (c == 11) begin
        check_eq("t4_idle", 64'(bus.dbg_state), 64'(IDLE));
        check_eq("t4_md_stall", 64'(bus.md_stall), 64'd0);
        check_eq("t4_busy", 64'(bus.busy), 64'd0);
      end
      if (c == 12) check_eq("t4_restart", 64'(bus.mul_start), 64'd1);
      if (c == 15) check_eq("t4_stall_done", 64'(bus.md_stall), 64'd0);
      if (c == 16) check_eq("t4_retired", 64'(bus.dbg_served), 64'd0);
      cyc();
    end

    // Test 4b: flush on the completion cycle suppresses the write
    idle_inputs();
    bus.req = 2'b10;
    set_lane(1, MD_MULTU, 32'd4, 32'd4);
    bus.mul_lo = 32'd16;
    for (int c = 0; c <= 3; c++) begin
      if (c == 2) bus.flush = 1'b1;
      if (c == 3) begin
        bus.flush = 1'b0;
        bus.req   = 2'b00;
      end
      @(negedge clk);
      check_eq("t4b_hilo_we", 64'(bus.hilo_we), 64'd0);
      if (c == 3) check_eq("t4b_idle", 64'(bus.dbg_state), 64'(IDLE));
      if (c == 3) check_eq("t4b_served", 64'(bus.dbg_served), 64'd0);
      cyc();
    end

    // Test 5: MULT under external stall t..t+8
    idle_inputs();
    bus.req       = 2'b10;
    bus.stall_ext = 1'b1;
    set_lane(1, MD_MULT, 32'd5, 32'd5);
    bus.mul_lo = 32'd25;
    exp_q.push_back(64'd25);
    n_start = 0;
    n_we    = 0;
    for (int c = 0; c <= 10; c++) begin
      if (c == 9) bus.stall_ext = 1'b0;
      if (c == 10) bus.req = 2'b00;
      @(negedge clk);
      n_start += int'(bus.mul_start);
      n_we    += int'(bus.hilo_we);
      if (c == 3) check_eq("t5_md_stall", 64'(bus.md_stall), 64'd0);
      if (c == 9) check_eq("t5_served_held", 64'(bus.dbg_served), 64'b10);
      if (c == 10) check_eq("t5_served_clr", 64'(bus.dbg_served), 64'd0);
      cyc();
    end
    check_eq("t5_n_start", 64'(n_start), 64'd1);
    check_eq("t5_n_we", 64'(n_we), 64'd1);

    // Test 6: reset mid-divide, then the divide re-presented
    idle_inputs();
    bus.req = 2'b10;
    set_lane(1, MD_DIVU, 32'd50, 32'd5);
    bus.div_q = 32'd10;
    bus.div_r = 32'd0;
    for (int c = 0; c <= 40; c++) begin
      if (c == 5) begin
        reset   = 1'b1;
        bus.req = 2'b00;
      end
      if (c == 6) reset = 1'b0;
      if (c == 7) begin
        bus.req = 2'b10;
        exp_q.push_back({32'd0, 32'd10});
      end
      if (c == 40) bus.req = 2'b00;
      @(negedge clk);
      check_eq("t6_hilo_we", 64'(bus.hilo_we), 64'(c == 38));
      if (c == 6) begin
        check_eq("t6_state", 64'(bus.dbg_state), 64'(IDLE));
        check_eq("t6_served", 64'(bus.dbg_served), 64'd0);
        check_eq("t6_outs", 64'({bus.md_stall, bus.busy, bus.mul_start, bus.div_start,
                                 bus.dp_signed}), 64'd0);
      end
      if (c >= 7) begin
        check_eq("t6_div_start", 64'(bus.div_start), 64'(c == 7));
        check_eq("t6_busy", 64'(bus.busy), 64'(c >= 8 && c <= 38));
      end
      cyc();
    end

    check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
